// File: rtl/db_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : db_timing_pkg
//  Purpose  : Shared types and helpers for the display-bus frame streamer:
//             timing region enum, sync/handshake bundle, total-length helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package db_timing_pkg;

  // Horizontal and vertical regions, in scan order.
  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FP     = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BP     = 2'd3
  } db_region_e;

  // Single-bit sync and handshake outputs, bundled so the bench can reuse them.
  typedef struct packed {
    logic hs;
    logic vs;
    logic df_uart;
    logic df_vga;
  } db_sync_s;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Map a counter value onto its region; the back porch is whatever remains.
  function automatic db_region_e region_of(input int cnt, input int act, input int fp,
                                           input int sync);
    if (cnt < act)                    return REG_ACTIVE;
    else if (cnt < act + fp)          return REG_FP;
    else if (cnt < act + fp + sync)   return REG_SYNC;
    else                              return REG_BP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/db_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : db_sync_fifo
//  Purpose  : Single-clock FIFO for UART bytes. Full/empty come from the
//             registered occupancy, so a pop never makes room for a push in
//             the same cycle and a push never feeds a pop in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module db_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             din,
  input  logic                          pop,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, cleared asynchronously so contents are discarded on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; no reset needed because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/db_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : db_frame_streamer
//  Purpose  : Display-bus master. Generates HS/VS timing, buffers UART bytes
//             in a FIFO and streams them as pixels during the active area.
//             Optional macro DB_TEST_PATTERN_EN: on an active cycle with an
//             empty FIFO, pixel shows h_cnt ^ v_cnt (DF_VGA stays 0).
//  Revision : 1.0 - initial release
// ============================================================================
module db_frame_streamer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] uart_data,
  input  logic              uart_valid,
  output logic              DF_UART,
  output logic              HS,
  output logic              VS,
  output logic              DF_VGA,
  output logic [DATA_W-1:0] pixel,
  output logic              underflow
);
  import db_timing_pkg::*;

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic              hs_q, hs_d, vs_q, vs_d;
  logic              df_vga_q, df_vga_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] pixel_q, pixel_d;

  db_region_e        h_region, v_region;
  logic              active, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  db_sync_s          sync_bus;

  assign h_region = region_of(int'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC);
  assign v_region = region_of(int'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC);
  assign active   = en && (h_region == REG_ACTIVE) && (v_region == REG_ACTIVE);
  // Empty is the registered state, so a byte arriving this cycle is not popped.
  assign fifo_pop = active && !fifo_empty;

  db_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (uart_valid),
    .din   (uart_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Counter advance, sync decode and pixel selection for the next output cycle.
  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    hs_d        = hs_q;
    vs_d        = vs_q;
    df_vga_d    = 1'b0;
    pixel_d     = '0;
    underflow_d = underflow_q;
    if (en) begin
      hs_d = (h_region == REG_SYNC) ? HS_POL : ~HS_POL;
      vs_d = (v_region == REG_SYNC) ? VS_POL : ~VS_POL;
      if (h_cnt_q == HW'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
      // Frame start clears the sticky flag; a same-cycle underflow below wins.
      if (h_cnt_q == '0 && v_cnt_q == '0) underflow_d = 1'b0;
    end
    if (fifo_pop) begin
      df_vga_d = 1'b1;
      pixel_d  = fifo_dout;
    end else if (active) begin
      underflow_d = 1'b1;
`ifdef DB_TEST_PATTERN_EN
      pixel_d = DATA_W'(h_cnt_q) ^ DATA_W'(v_cnt_q);
`endif
    end
  end

  // Timing counters and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      df_vga_q    <= 1'b0;
      pixel_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      df_vga_q    <= df_vga_d;
      pixel_q     <= pixel_d;
      underflow_q <= underflow_d;
    end
  end

  assign sync_bus = '{hs: hs_q, vs: vs_q, df_uart: ~fifo_full, df_vga: df_vga_q};

  assign HS        = sync_bus.hs;
  assign VS        = sync_bus.vs;
  assign DF_UART   = sync_bus.df_uart;
  assign DF_VGA    = sync_bus.df_vga;
  assign pixel     = pixel_q;
  assign underflow = underflow_q;

  // The FIFO's full flag must always agree with its occupancy count.
  a_full_matches_count: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_db_frame_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_db_frame_streamer
//  Purpose  : Self-checking bench for db_frame_streamer with a small frame
//             (8 x 5 clocks, 4-entry FIFO) and a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_db_frame_streamer;
  import db_timing_pkg::*;

  localparam int HA = 4, HFP = 1, HSY = 2, HBP = 1;
  localparam int VA = 2, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int DEPTH = 4;
  localparam bit HS_POL = 1'b0, VS_POL = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       uart_valid = 1'b0;
  logic       DF_UART, HS, VS, DF_VGA, underflow;
  logic [7:0] pixel;

  int checks = 0;
  int failures = 0;

  db_frame_streamer #(
    .DATA_W(8), .FIFO_DEPTH(DEPTH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .uart_data(uart_data), .uart_valid(uart_valid),
    .DF_UART(DF_UART), .HS(HS), .VS(VS), .DF_VGA(DF_VGA), .pixel(pixel),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: position in frame + byte queue ----------
  int         m_h, m_v;
  logic [7:0] m_q[$];
  logic       m_hs, m_vs, m_dfvga, m_und;
  logic [7:0] m_pix;

  function automatic logic [7:0] pat(input int h, input int v);
`ifdef DB_TEST_PATTERN_EN
    return 8'(h ^ v);
`else
    return 8'h00;
`endif
  endfunction

  function automatic void model_reset();
    m_h = 0; m_v = 0; m_q.delete();
    m_hs = !HS_POL; m_vs = !VS_POL; m_dfvga = 1'b0; m_und = 1'b0; m_pix = 8'h00;
  endfunction

  function automatic void model_update(input logic e, input logic v, input logic [7:0] d);
    bit act, do_pop, do_push;
    int sz;
    sz      = m_q.size();
    act     = e && (m_h < HA) && (m_v < VA);
    do_pop  = act && (sz > 0);
    do_push = v && (sz < DEPTH);
    m_dfvga = do_pop;
    m_pix   = 8'h00;
    if (e && m_h == 0 && m_v == 0) m_und = 1'b0;
    if (do_pop) m_pix = m_q.pop_front();
    else if (act) begin
      m_und = 1'b1;
      m_pix = pat(m_h, m_v);
    end
    if (do_push) m_q.push_back(d);
    if (e) begin
      m_hs = (m_h >= HA + HFP && m_h < HA + HFP + HSY) ? HS_POL : !HS_POL;
      m_vs = (m_v >= VA + VFP && m_v < VA + VFP + VSY) ? VS_POL : !VS_POL;
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".HS"}, 32'(HS), 32'(m_hs));
    chk({tag, ".VS"}, 32'(VS), 32'(m_vs));
    chk({tag, ".DF_VGA"}, 32'(DF_VGA), 32'(m_dfvga));
    chk({tag, ".pixel"}, 32'(pixel), 32'(m_pix));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_und));
    chk({tag, ".DF_UART"}, 32'(DF_UART), 32'(m_q.size() < DEPTH));
    chk({tag, ".count"}, 32'(dut.fifo_count), 32'(m_q.size()));
  endtask

  task automatic step(input string tag, input logic e, input logic v, input logic [7:0] d);
    en = e; uart_valid = v; uart_data = d;
    @(posedge clk);
    model_update(e, v, d);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; uart_valid = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed table for the preload/stream case ---------------
  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    db_sync_s   exp;
    logic [7:0] exp_pixel;
    logic       exp_und;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int ones;
    int h;
    db_sync_s got;

    // 8 writes with timing frozen: only the first 4 fit.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{en: 1'b0, valid: 1'b1, data: 8'(8'h10 + i),
                  exp: '{hs: 1'b1, vs: 1'b1, df_uart: (i < 3), df_vga: 1'b0},
                  exp_pixel: 8'h00, exp_und: 1'b0};
    // First 12 clocks of the frame: line 0 drains the FIFO, line 1 underflows.
    for (int k = 0; k < 12; k++) begin
      h = k % 8;
      vecs[8 + k] = '{en: 1'b1, valid: 1'b0, data: 8'h00,
                      exp: '{hs: !(h == 5 || h == 6), vs: 1'b1, df_uart: 1'b1, df_vga: (k < 4)},
                      exp_pixel: (k < 4) ? 8'(8'h10 + k) : ((k >= 8) ? pat(h, 1) : 8'h00),
                      exp_und: (k >= 8)};
    end

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    #1;
    chk("reset.HS", 32'(HS), 32'(!HS_POL));
    chk("reset.VS", 32'(VS), 32'(!VS_POL));
    chk("reset.DF_UART", 32'(DF_UART), 32'd1);
    chk("reset.DF_VGA", 32'(DF_VGA), 32'd0);
    chk("reset.pixel", 32'(pixel), 32'd0);
    chk("reset.underflow", 32'(underflow), 32'd0);

    // Idle frame: no traffic
    ones = 0;
    for (int c = 0; c < HT * VT; c++) begin
      step("idle", 1'b1, 1'b0, 8'h00);
      if (c == 0) chk("idle.und_first", 32'(underflow), 32'd1);
      ones += int'(DF_VGA);
    end
    chk("idle.vga_count", 32'(ones), 32'd0);

    // Table: preload then stream
    do_reset();
    for (int i = 0; i < 20; i++) begin
      en = vecs[i].en; uart_valid = vecs[i].valid; uart_data = vecs[i].data;
      @(posedge clk);
      #1;
      got = '{hs: HS, vs: VS, df_uart: DF_UART, df_vga: DF_VGA};
      chk($sformatf("tbl[%0d].sync", i), 32'(got), 32'(vecs[i].exp));
      chk($sformatf("tbl[%0d].pixel", i), 32'(pixel), 32'(vecs[i].exp_pixel));
      chk($sformatf("tbl[%0d].underflow", i), 32'(underflow), 32'(vecs[i].exp_und));
    end

    // Continuous UART traffic for three frames
    do_reset();
    for (int f = 0; f < 3; f++) begin
      ones = 0;
      for (int c = 0; c < HT * VT; c++) begin
        step("stream", 1'b1, 1'b1, 8'($urandom));
        ones += int'(DF_VGA);
        if (f > 0) chk("stream.und_clear", 32'(underflow), 32'd0);
      end
      if (f > 0) chk("stream.vga_count", 32'(ones), 32'(HA * VA));
    end

    // Push+pop at full: push blocked, pop proceeds
    do_reset();
    for (int i = 0; i < 4; i++) step("full.pre", 1'b0, 1'b1, 8'(8'hA0 + i));
    step("full.pp", 1'b1, 1'b1, 8'hB0);
    chk("full.count", 32'(dut.fifo_count), 32'd3);
    chk("full.pixel", 32'(pixel), 32'hA0);
    for (int i = 0; i < 6; i++) step("full.post", 1'b1, 1'b1, 8'(8'hB1 + i));

    // Push at empty during active: byte lands, nothing popped
    do_reset();
    step("empty.pp", 1'b1, 1'b1, 8'hC0);
    chk("empty.count", 32'(dut.fifo_count), 32'd1);
    chk("empty.DF_VGA", 32'(DF_VGA), 32'd0);
    step("empty.next", 1'b1, 1'b0, 8'h00);
    chk("empty.pixel", 32'(pixel), 32'hC0);

    // Enable low for 5 clocks mid-line while bytes arrive
    do_reset();
    step("en.pre", 1'b1, 1'b0, 8'h00);
    step("en.pre", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step("en.off", 1'b0, 1'b1, 8'(8'hD0 + i));
    chk("en.count", 32'(dut.fifo_count), 32'd4);
    for (int i = 0; i < 45; i++) step("en.on", 1'b1, 1'b0, 8'h00);

    // Asynchronous reset in the middle of streaming
    do_reset();
    for (int i = 0; i < 4; i++) step("arst.pre", 1'b0, 1'b1, 8'(8'hE0 + i));
    step("arst.pre", 1'b1, 1'b1, 8'hE8);
    step("arst.pre", 1'b1, 1'b1, 8'hE9);
    #2 rst = 1'b1;
    #1;
    chk("arst.HS", 32'(HS), 32'(!HS_POL));
    chk("arst.VS", 32'(VS), 32'(!VS_POL));
    chk("arst.DF_VGA", 32'(DF_VGA), 32'd0);
    chk("arst.pixel", 32'(pixel), 32'd0);
    chk("arst.DF_UART", 32'(DF_UART), 32'd1);
    chk("arst.count", 32'(dut.fifo_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) step("arst.post", 1'b1, 1'b0, 8'h00);

    // Randomised traffic, enable and density
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int dens;
      dens = $urandom_range(1, 4);
      for (int c = 0; c < 100; c++)
        step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) < dens), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
